// File: rtl/inv_zig_zag.sv
// Inverse zig-zag reorder: takes 8x8 coefficient blocks in JPEG zig-zag order
// and emits them in DCT column order (beat n = row n%8, column n/8).
// Two ping-pong register banks let one block fill while the other drains.
module inv_zig_zag #(
   parameter  int unsigned DCT_WIDTH       = 12,
   localparam int unsigned DCT_TDATA_WIDTH = ((DCT_WIDTH + 7) / 8) * 8
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   // zig-zag ordered input stream
   input  logic                         zz_i_tvalid,
   output logic                         zz_i_tready,
   input  logic [DCT_TDATA_WIDTH-1:0]   zz_i_tdata,
   input  logic                         zz_i_tlast,
   input  logic                         zz_i_tuser,
   // column ordered output stream
   output logic                         dct_o_tvalid,
   input  logic                         dct_o_tready,
   output logic [DCT_TDATA_WIDTH-1:0]   dct_o_tdata,
   output logic                         dct_o_tlast,
   output logic                         dct_o_tuser,
   output logic [DCT_TDATA_WIDTH/8-1:0] dct_o_tstrb,
   output logic [DCT_TDATA_WIDTH/8-1:0] dct_o_tkeep
);

   localparam int unsigned NB_STRB = DCT_TDATA_WIDTH / 8;
   localparam int unsigned CNT_W   = 6;

   // Zig-zag position of the coefficient at (row n%8, col n/8).
   localparam logic [CNT_W-1:0] RD_ADDR [64] = '{
      6'd0,  6'd2,  6'd3,  6'd9,  6'd10, 6'd20, 6'd21, 6'd35,
      6'd1,  6'd4,  6'd8,  6'd11, 6'd19, 6'd22, 6'd34, 6'd36,
      6'd5,  6'd7,  6'd12, 6'd18, 6'd23, 6'd33, 6'd37, 6'd48,
      6'd6,  6'd13, 6'd17, 6'd24, 6'd32, 6'd38, 6'd47, 6'd49,
      6'd14, 6'd16, 6'd25, 6'd31, 6'd39, 6'd46, 6'd50, 6'd57,
      6'd15, 6'd26, 6'd30, 6'd40, 6'd45, 6'd51, 6'd56, 6'd58,
      6'd27, 6'd29, 6'd41, 6'd44, 6'd52, 6'd55, 6'd59, 6'd62,
      6'd28, 6'd42, 6'd43, 6'd53, 6'd54, 6'd60, 6'd61, 6'd63
   };

   // FILL: read bank empty. DRAIN: read bank draining, write bank filling.
   // WAIT: write bank full, held until the read bank drains.
   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic                   w_swap;

   logic [DCT_WIDTH-1:0]   r_bank [2][64];
   logic                   r_rd_sel;
   logic [CNT_W-1:0]       r_rd_cnt;
   logic [CNT_W-1:0]       r_wr_cnt;
   logic [1:0]             r_tlast_flag;
   logic [1:0]             r_tuser_flag;

   logic                   r_tvalid;
   logic [DCT_TDATA_WIDTH-1:0] r_tdata;
   logic                   r_tlast;
   logic                   r_tuser;

   logic                   w_wr_bank;
   logic                   w_wr_acc;
   logic                   w_wr_last;
   logic                   w_rd_acc;
   logic                   w_rd_last;
   logic                   w_rd_sel_nxt;
   logic [CNT_W-1:0]       w_rd_cnt_nxt;
   logic                   w_tvalid_nxt;
   logic [1:0]             w_tlast_flag_nxt;
   logic [1:0]             w_tuser_flag_nxt;
   logic [DCT_WIDTH-1:0]   w_rd_word;
   logic                   w_unused;

   assign w_unused  = ^zz_i_tdata;

   assign w_wr_acc  = zz_i_tvalid & zz_i_tready;
   assign w_wr_last = w_wr_acc & (r_wr_cnt == CNT_W'(63));
   assign w_rd_acc  = r_tvalid & dct_o_tready;
   assign w_rd_last = w_rd_acc & (r_rd_cnt == CNT_W'(63));

   // Control state register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_FILL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and bank-swap decision
   always_comb begin
      w_state_nxt = r_state;
      w_swap      = 1'b0;
      unique case (r_state)
         ST_FILL: begin
            if (w_wr_last) begin
               w_state_nxt = ST_DRAIN;
               w_swap      = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (w_wr_last && w_rd_last) begin
               w_swap = 1'b1;
            end else if (w_wr_last) begin
               w_state_nxt = ST_WAIT;
            end else if (w_rd_last) begin
               w_state_nxt = ST_FILL;
            end
         end
         ST_WAIT: begin
            if (w_rd_last) begin
               w_state_nxt = ST_DRAIN;
               w_swap      = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_FILL;
         end
      endcase
   end

   // Input ready and write-bank target; in WAIT the draining bank is freed on its last beat
   always_comb begin
      zz_i_tready = 1'b1;
      w_wr_bank   = ~r_rd_sel;
      if (r_state == ST_WAIT) begin
         zz_i_tready = w_rd_last;
         w_wr_bank   = r_rd_sel;
      end
   end

   // Sideband flags: first beat of a block restarts the OR, later beats accumulate
   always_comb begin
      w_tlast_flag_nxt = r_tlast_flag;
      w_tuser_flag_nxt = r_tuser_flag;
      if (w_wr_acc) begin
         if (r_wr_cnt == '0) begin
            w_tlast_flag_nxt[w_wr_bank] = zz_i_tlast;
            w_tuser_flag_nxt[w_wr_bank] = zz_i_tuser;
         end else begin
            w_tlast_flag_nxt[w_wr_bank] = r_tlast_flag[w_wr_bank] | zz_i_tlast;
            w_tuser_flag_nxt[w_wr_bank] = r_tuser_flag[w_wr_bank] | zz_i_tuser;
         end
      end
   end

   // Next read position; the addressed word is never written in the same cycle
   always_comb begin
      w_rd_sel_nxt = r_rd_sel ^ w_swap;
      w_rd_cnt_nxt = r_rd_cnt + CNT_W'(w_rd_acc);
      w_tvalid_nxt = (w_state_nxt != ST_FILL);
      w_rd_word    = r_bank[w_rd_sel_nxt][RD_ADDR[w_rd_cnt_nxt]];
   end

   // Coefficient storage, written sequentially by input beat index
   always_ff @(posedge clk_i) begin
      if (!rst_i && w_wr_acc) begin
         r_bank[w_wr_bank][r_wr_cnt] <= zz_i_tdata[DCT_WIDTH-1:0];
      end
   end

   // Counters, bank select, flags and registered output beat
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rd_sel     <= 1'b0;
         r_rd_cnt     <= '0;
         r_wr_cnt     <= '0;
         r_tlast_flag <= '0;
         r_tuser_flag <= '0;
         r_tvalid     <= 1'b0;
         r_tdata      <= '0;
         r_tlast      <= 1'b0;
         r_tuser      <= 1'b0;
      end else begin
         r_rd_sel     <= w_rd_sel_nxt;
         r_rd_cnt     <= w_rd_cnt_nxt;
         r_wr_cnt     <= r_wr_cnt + CNT_W'(w_wr_acc);
         r_tlast_flag <= w_tlast_flag_nxt;
         r_tuser_flag <= w_tuser_flag_nxt;
         r_tvalid     <= w_tvalid_nxt;
         r_tdata      <= w_tvalid_nxt ? DCT_TDATA_WIDTH'($signed(w_rd_word)) : '0;
         r_tlast      <= w_tvalid_nxt && (w_rd_cnt_nxt == CNT_W'(63)) && w_tlast_flag_nxt[w_rd_sel_nxt];
         r_tuser      <= w_tvalid_nxt && (w_rd_cnt_nxt == '0) && w_tuser_flag_nxt[w_rd_sel_nxt];
      end
   end

   assign dct_o_tvalid = r_tvalid;
   assign dct_o_tdata  = r_tdata;
   assign dct_o_tlast  = r_tlast;
   assign dct_o_tuser  = r_tuser;
   assign dct_o_tstrb  = {NB_STRB{1'b1}};
   assign dct_o_tkeep  = {NB_STRB{1'b1}};

endmodule
